// File: rtl/rwg_weight_loader_if.sv
// ============================================================================
// Module      : rwg_weight_loader_if
// Description : Control, rwg-side and buffer read-port bundle for the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rwg_weight_loader_if #(
  parameter int NUM_GEN = 12,
  parameter int WIDTH   = 11,
  parameter int ADDR_W  = 6
);
  logic               start;
  logic               busy;
  logic               done;
  logic               weights_ready;
  logic [NUM_GEN-1:0] en_lfsr;
  logic [WIDTH-1:0]   lfsr_random;
  logic               wt_valid;
  logic [WIDTH-1:0]   wt_data;
  logic [ADDR_W-1:0]  wt_index;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_valid;

  // Master is the controlling side (datapath plus rwg), slave is the loader.
  modport master (
    output start, lfsr_random, rd_en, rd_addr,
    input  busy, done, weights_ready, en_lfsr,
    input  wt_valid, wt_data, wt_index, rd_data, rd_valid
  );

  modport slave (
    input  start, lfsr_random, rd_en, rd_addr,
    output busy, done, weights_ready, en_lfsr,
    output wt_valid, wt_data, wt_index, rd_data, rd_valid
  );
endinterface

`default_nettype wire

// File: rtl/rwg_weight_loader.sv
// ============================================================================
// Module      : rwg_weight_loader
// Description : Seeds/runs each rwg LFSR, captures weights into a buffer,
//               and serves the buffer through a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rwg_weight_loader #(
  parameter int NUM_GEN    = 12,
  parameter int WIDTH      = 11,
  parameter int RUN_CYCLES = 12,
  parameter int NUM_ROUNDS = 5,
  parameter int ADDR_W     = 6
) (
  input  wire logic         clk2,
  input  wire logic         rst,
  rwg_weight_loader_if.slave bus
);

  localparam int c_total   = NUM_GEN * NUM_ROUNDS;
  localparam int c_depth   = 1 << ADDR_W;
  localparam int c_gen_w   = (NUM_GEN > 1)    ? $clog2(NUM_GEN)        : 1;
  localparam int c_run_w   = $clog2(RUN_CYCLES + 1);
  localparam int c_round_w = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS)     : 1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_seed = 2'd1;
  localparam logic [1:0] c_st_run  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [c_gen_w-1:0]   c_gen_last   = c_gen_w'(NUM_GEN - 1);
  localparam logic [c_gen_w-1:0]   c_gen_one    = c_gen_w'(1);
  localparam logic [c_run_w-1:0]   c_run_last   = c_run_w'(RUN_CYCLES - 1);
  localparam logic [c_run_w-1:0]   c_run_one    = c_run_w'(1);
  localparam logic [c_round_w-1:0] c_round_last = c_round_w'(NUM_ROUNDS - 1);
  localparam logic [c_round_w-1:0] c_round_one  = c_round_w'(1);
  localparam logic [ADDR_W:0]      c_total_p    = (ADDR_W + 1)'(c_total);
  localparam logic [ADDR_W:0]      c_ptr_one    = (ADDR_W + 1)'(1);

  logic [1:0]           r_state;
  logic [c_gen_w-1:0]   r_gen;
  logic [c_run_w-1:0]   r_run_cnt;
  logic [c_round_w-1:0] r_round;
  // One extra bit so the pointer can rest at c_total without wrapping.
  logic [ADDR_W:0]      r_wr_ptr;
  logic                 r_weights_ready;
  logic                 r_wt_valid;
  logic [WIDTH-1:0]     r_wt_data;
  logic [ADDR_W-1:0]    r_wt_index;
  logic [WIDTH-1:0]     r_rd_data;
  logic                 r_rd_valid;
  logic [WIDTH-1:0]     r_mem [0:c_depth-1];

  logic                 w_capture;
  logic                 w_wr_ok;
  logic                 w_rd_in_range;
  logic [NUM_GEN-1:0]   w_en_lfsr;

  assign w_capture     = (r_state == c_st_run) && (r_run_cnt == c_run_last);
  assign w_wr_ok       = (r_wr_ptr < c_total_p);
  assign w_rd_in_range = ({1'b0, bus.rd_addr} < c_total_p);

  // Only the generator being seeded sees its enable low.
  always_comb begin
    w_en_lfsr = '1;
    if (r_state == c_st_seed) begin
      w_en_lfsr[r_gen] = 1'b0;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      r_state         <= c_st_idle;
      r_gen           <= '0;
      r_run_cnt       <= '0;
      r_round         <= '0;
      r_wr_ptr        <= '0;
      r_weights_ready <= 1'b0;
      r_wt_valid      <= 1'b0;
      r_wt_data       <= '0;
      r_wt_index      <= '0;
    end else begin
      r_wt_valid <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (bus.start) begin
            r_state         <= c_st_seed;
            r_gen           <= '0;
            r_round         <= '0;
            r_run_cnt       <= '0;
            r_wr_ptr        <= '0;
            r_weights_ready <= 1'b0;
          end
        end
        c_st_seed: begin
          r_state   <= c_st_run;
          r_run_cnt <= '0;
        end
        c_st_run: begin
          r_run_cnt <= r_run_cnt + c_run_one;
          if (w_capture) begin
            r_wt_valid <= 1'b1;
            r_wt_data  <= bus.lfsr_random;
            r_wt_index <= r_wr_ptr[ADDR_W-1:0];
            if (w_wr_ok) begin
              r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (r_gen != c_gen_last) begin
              r_gen   <= r_gen + c_gen_one;
              r_state <= c_st_seed;
            end else begin
              r_gen <= '0;
              if (r_round != c_round_last) begin
                r_round <= r_round + c_round_one;
                r_state <= c_st_seed;
              end else begin
                r_state         <= c_st_done;
                r_weights_ready <= 1'b1;
              end
            end
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Buffer storage is deliberately not reset so a partial load survives rst.
  always_ff @(posedge clk2) begin
    if (w_capture && w_wr_ok) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.lfsr_random;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      r_rd_data  <= w_rd_in_range ? r_mem[bus.rd_addr] : '0;
    end
  end

  assign bus.busy          = (r_state != c_st_idle);
  assign bus.done          = (r_state == c_st_done);
  assign bus.weights_ready = r_weights_ready;
  assign bus.en_lfsr       = w_en_lfsr;
  assign bus.wt_valid      = r_wt_valid;
  assign bus.wt_data       = r_wt_data;
  assign bus.wt_index      = r_wt_index;
  assign bus.rd_data       = r_rd_data;
  assign bus.rd_valid      = r_rd_valid;

endmodule

`default_nettype wire
